// File: rtl/neuron_accumulator.sv
// Neuron pre-activation: streams pixel/weight pairs, accumulates signed products on a bias.
// Latency: SCALE follows the last accepted beat; zed_valid rises on the edge after that.
// Backpressure: in_ready only in ACCUM; zed/zed_valid held in DONE until zed_ready.
module neuron_accumulator #(
   parameter int N_INPUTS = 784,
   parameter int ACC_W    = 24,
   parameter int SHIFT    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic signed [15:0] bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        pixel,
   input  logic signed [7:0] weight,
   output logic              zed_valid,
   input  logic              zed_ready,
   output logic [7:0]        zed,
   output logic              busy
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] Z_MAX   = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] Z_MIN   = ACC_W'(-128);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCALE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    in_ready_q, in_ready_d;
   logic                    zed_valid_q, zed_valid_d;
   logic [7:0]              zed_q, zed_d;
   logic                    busy_q, busy_d;

   logic signed [16:0]      pix_ext;
   logic signed [16:0]      wgt_ext;
   logic signed [16:0]      product;
   logic signed [ACC_W:0]   sum_wide;
   logic signed [ACC_W-1:0] acc_sat;
   logic signed [ACC_W-1:0] scaled;
   logic [7:0]              clamped;
   logic                    beat;

   // Datapath: 17-bit signed product, saturating add, floor shift and 8-bit clamp
   always_comb begin
      pix_ext  = {9'b0, pixel};
      wgt_ext  = {{9{weight[7]}}, weight};
      product  = pix_ext * wgt_ext;
      sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-16){product[16]}}, product};
      // Top two bits disagree only when the add left the ACC_W signed range
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
         acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_sat = sum_wide[ACC_W-1:0];
      end
      scaled = acc_q >>> SHIFT;
      if (scaled > Z_MAX) begin
         clamped = 8'h7f;
      end else if (scaled < Z_MIN) begin
         clamped = 8'h80;
      end else begin
         clamped = scaled[7:0];
      end
   end

   // Next-state and registered-output logic for the inference FSM
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      zed_valid_d = zed_valid_q;
      zed_d       = zed_q;
      beat        = in_valid && in_ready_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = {{(ACC_W-16){bias[15]}}, bias};
               count_d = '0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat) begin
               acc_d   = acc_sat;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
                  state_d = S_SCALE;
               end
            end
         end
         S_SCALE: begin
            // Offset binary: inverting the MSB adds 128 to the two's-complement code
            zed_d       = {~clamped[7], clamped[6:0]};
            zed_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (zed_ready) begin
               zed_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_ACCUM);
      busy_d     = (state_d != S_IDLE);
   end

   // State and output registers; synchronous reset discards any partial sum
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         zed_valid_q <= 1'b0;
         zed_q       <= 8'd128;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         zed_valid_q <= zed_valid_d;
         zed_q       <= zed_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign zed_valid = zed_valid_q;
   assign zed       = zed_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator with N_INPUTS=4: directed vector table,
// backpressure/reset sequences and randomized inferences against a model.
module tb_neuron_accumulator;

   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic signed [15:0] bias;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        pixel;
   logic signed [7:0] weight;
   logic              zed_valid;
   logic              zed_ready;
   logic [7:0]        zed;
   logic              busy;

   int checks = 0;
   int errors = 0;

   neuron_accumulator #(.N_INPUTS(N), .ACC_W(24), .SHIFT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .pixel(pixel), .weight(weight),
      .zed_valid(zed_valid), .zed_ready(zed_ready), .zed(zed), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    b;
      int    p[N];
      int    w[N];
      int    exp_zed;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, saturate to 24-bit, floor divide by 256, clamp
   function automatic int model(input int b, input int p[N], input int w[N]);
      longint acc;
      longint s;
      acc = b;
      for (int i = 0; i < N; i++) begin
         acc = acc + longint'(p[i]) * longint'(w[i]);
         if (acc > 8388607) acc = 8388607;
         if (acc < -8388608) acc = -8388608;
      end
      if (acc >= 0) s = acc / 256;
      else s = -((-acc + 255) / 256);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return int'(s) + 128;
   endfunction

   // One full inference; rnd adds idle gaps, stray start pulses and output stalls
   task automatic run_inf(input int b, input int p[N], input int w[N], input bit rnd, output int z);
      int n;
      int stall;
      logic [7:0] held;
      start = 1'b1;
      bias  = 16'(b);
      tick();
      start = 1'b0;
      chk("busy_after_start", {31'b0, busy}, 1);
      for (int i = 0; i < N; i++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               start    = 1'($urandom_range(0, 1));
               bias     = 16'($urandom);
               pixel    = 8'($urandom);
               tick();
            end
         end
         in_valid = 1'b1;
         pixel    = 8'(p[i]);
         weight   = 8'(w[i]);
         n = 0;
         while (!in_ready && n < 20) begin
            tick();
            n++;
         end
         if (!in_ready) chk("in_ready_timeout", 0, 1);
         tick();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("zed_valid_scale_cycle", {31'b0, zed_valid}, 0);
      chk("in_ready_scale_cycle", {31'b0, in_ready}, 0);
      tick();
      chk("zed_valid_latency", {31'b0, zed_valid}, 1);
      held = zed;
      z = int'(zed);
      if (rnd) begin
         stall = $urandom_range(0, 3);
         for (int k = 0; k < stall; k++) begin
            start    = 1'b1;
            in_valid = 1'b1;
            tick();
            chk("zed_hold", {24'b0, zed}, {24'b0, held});
         end
         start    = 1'b0;
         in_valid = 1'b0;
      end
      zed_ready = 1'b1;
      tick();
      zed_ready = 1'b0;
      chk("zed_valid_clear", {31'b0, zed_valid}, 0);
      chk("zed_keep", {24'b0, zed}, {24'b0, held});
      chk("busy_idle", {31'b0, busy}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int z;
      int p[N];
      int w[N];

      vecs[0] = '{"zero_weights",   0,      '{10, 20, 30, 40},     '{0, 0, 0, 0},             128};
      vecs[1] = '{"pos_clamp",      0,      '{255, 255, 255, 255}, '{127, 127, 127, 127},     255};
      vecs[2] = '{"neg_small",      0,      '{16, 16, 16, 16},     '{-16, -16, -16, -16},     124};
      vecs[3] = '{"floor_minus1",   -1,     '{9, 9, 9, 9},         '{0, 0, 0, 0},             127};
      vecs[4] = '{"bias_512",       512,    '{1, 2, 3, 4},         '{0, 0, 0, 0},             130};
      vecs[5] = '{"neg_clamp",      -32768, '{255, 255, 255, 255}, '{-128, -128, -128, -128}, 0};
      vecs[6] = '{"round_boundary", 255,    '{1, 1, 1, 1},         '{1, 1, 1, 1},             129};

      rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
      pixel = '0; weight = '0; zed_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_in_ready", {31'b0, in_ready}, 0);
      chk("reset_zed_valid", {31'b0, zed_valid}, 0);
      chk("reset_zed", {24'b0, zed}, 128);
      chk("reset_busy", {31'b0, busy}, 0);

      // zed_ready and in_valid in IDLE do nothing
      zed_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      zed_ready = 1'b0;
      in_valid  = 1'b0;
      chk("idle_zed_ready_valid", {31'b0, zed_valid}, 0);
      chk("idle_in_ready", {31'b0, in_ready}, 0);
      chk("idle_zed", {24'b0, zed}, 128);

      for (int v = 0; v < 7; v++) begin
         run_inf(vecs[v].b, vecs[v].p, vecs[v].w, 1'b0, z);
         chk(vecs[v].name, z, vecs[v].exp_zed);
      end

      // Output backpressure: zed_ready low 3 cycles while in_valid toggles and start pulses
      start = 1'b1;
      bias  = 16'sd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1; pixel = 8'd255; weight = 8'sd127;
         tick();
      end
      in_valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         in_valid = ~in_valid;
         start    = 1'b1;
         bias     = 16'sd100;
         tick();
         chk("bp_zed", {24'b0, zed}, 255);
         chk("bp_zed_valid", {31'b0, zed_valid}, 1);
         chk("bp_in_ready", {31'b0, in_ready}, 0);
         chk("bp_busy", {31'b0, busy}, 1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      zed_ready = 1'b1;
      tick();
      zed_ready = 1'b0;
      chk("bp_release", {31'b0, zed_valid}, 0);
      tick();
      chk("bp_no_restart", {31'b0, busy}, 0);

      // Reset mid-accumulation, with start asserted in the same cycle
      start = 1'b1;
      bias  = 16'sd512;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; pixel = 8'd255; weight = 8'sd127;
         tick();
      end
      in_valid = 1'b0;
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_mid_in_ready", {31'b0, in_ready}, 0);
      chk("rst_mid_zed_valid", {31'b0, zed_valid}, 0);
      chk("rst_mid_zed", {24'b0, zed}, 128);
      chk("rst_mid_busy", {31'b0, busy}, 0);
      run_inf(vecs[2].b, vecs[2].p, vecs[2].w, 1'b0, z);
      chk("restart_after_rst", z, 124);

      // Randomized inferences against the reference model
      for (int r = 0; r < 40; r++) begin
         int b;
         b = int'($signed(16'($urandom)));
         if (r % 4 == 0) b = (r % 8 == 0) ? 32767 : -32768;
         for (int i = 0; i < N; i++) begin
            p[i] = $urandom_range(0, 255);
            w[i] = int'($signed(8'($urandom)));
         end
         run_inf(b, p, w, 1'b1, z);
         chk("random_zed", z, model(b, p, w));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
